// File: rtl/axi3_pkg.sv
// Shared AXI3 encodings, widths and burst decode helper for the HP slave RAM.
// Imported by the burst address calculator and the RAM top.
package axi3_pkg;

   localparam int unsigned ID_W  = 6;
   localparam int unsigned LEN_W = 4;
   localparam int unsigned CNT_W = LEN_W + 1;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] BURST_WRAP  = 2'b10;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   localparam logic [2:0] SIZE_4B = 3'b010;

   typedef enum logic [1:0] {WrIdle, WrData, WrResp} wr_state_e;
   typedef enum logic {RdIdle, RdData} rd_state_e;

   // Burst-level response, fixed at address accept. Decode errors win over size/burst errors.
   function automatic logic [1:0] burst_resp(input logic [31:0]      addr,
                                             input logic [31:0]      base,
                                             input int unsigned      aw,
                                             input logic [2:0]       size,
                                             input logic [1:0]       burst,
                                             input logic [LEN_W-1:0] len);
      logic [31:0]      off;
      logic [LEN_W-1:0] len_p1;
      off    = addr - base;
      len_p1 = len + LEN_W'(1);
      if (addr < base || (off >> (aw + 2)) != 0) return RESP_DECERR;
      if (size != SIZE_4B || burst == 2'b11) return RESP_SLVERR;
      if (burst == BURST_WRAP && (len == '0 || (len & len_p1) != '0)) return RESP_SLVERR;
      return RESP_OKAY;
   endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// Next word index for an AXI3 burst beat; WRAP bursts stay inside their (len+1)-word window.
module axi_burst_addr
   import axi3_pkg::*;
#(
   parameter int unsigned MEM_AW = 10
) (
   input  logic [MEM_AW-1:0] idx_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic [1:0]        burst_i,
   output logic [MEM_AW-1:0] next_idx_o
);

   logic [MEM_AW-1:0] incr;
   logic [MEM_AW-1:0] mask;

   assign incr = idx_i + MEM_AW'(1);
   // Legal WRAP lengths (1/3/7/15) are already the in-window word mask.
   assign mask = MEM_AW'(len_i);

   always_comb begin
      next_idx_o = incr;
      case (burst_i)
         BURST_FIXED: next_idx_o = idx_i;
         BURST_WRAP:  next_idx_o = (idx_i & ~mask) | (incr & mask);
         default:     next_idx_o = incr;
      endcase
   end

endmodule

// File: rtl/axi_hp_slave_ram.sv
// AXI3 slave backed by a local word array; independent single-outstanding read and write engines.
// Array reads are asynchronous, writes are synchronous with byte enables.
module axi_hp_slave_ram
   import axi3_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
   parameter int unsigned MEM_AW    = 10
) (
   input  logic             AXI_clk,
   input  logic             rst,
   input  logic [31:0]      AXI_awaddr,
   input  logic [ID_W-1:0]  AXI_awid,
   input  logic [LEN_W-1:0] AXI_awlen,
   input  logic [2:0]       AXI_awsize,
   input  logic [1:0]       AXI_awburst,
   input  logic [1:0]       AXI_awlock,
   input  logic [3:0]       AXI_awcache,
   input  logic [2:0]       AXI_awprot,
   input  logic [3:0]       AXI_awqos,
   input  logic             AXI_awvalid,
   output logic             AXI_awready,
   input  logic [31:0]      AXI_wdata,
   input  logic [ID_W-1:0]  AXI_wid,
   input  logic [3:0]       AXI_wstrb,
   input  logic             AXI_wlast,
   input  logic             AXI_wvalid,
   output logic             AXI_wready,
   output logic [ID_W-1:0]  AXI_bid,
   output logic [1:0]       AXI_bresp,
   output logic             AXI_bvalid,
   input  logic             AXI_bready,
   input  logic [31:0]      AXI_araddr,
   input  logic [ID_W-1:0]  AXI_arid,
   input  logic [LEN_W-1:0] AXI_arlen,
   input  logic [2:0]       AXI_arsize,
   input  logic [1:0]       AXI_arburst,
   input  logic [1:0]       AXI_arlock,
   input  logic [3:0]       AXI_arcache,
   input  logic [2:0]       AXI_arprot,
   input  logic [3:0]       AXI_arqos,
   input  logic             AXI_arvalid,
   output logic             AXI_arready,
   output logic [31:0]      AXI_rdata,
   output logic [ID_W-1:0]  AXI_rid,
   output logic [1:0]       AXI_rresp,
   output logic             AXI_rlast,
   output logic             AXI_rvalid,
   input  logic             AXI_rready
);

   logic [31:0] mem [2**MEM_AW];

   // Write engine state
   wr_state_e         w_state;
   logic [ID_W-1:0]   w_id;
   logic [MEM_AW-1:0] w_idx;
   logic [MEM_AW-1:0] w_idx_next;
   logic [LEN_W-1:0]  w_len;
   logic [1:0]        w_burst;
   logic [1:0]        w_resp;
   logic [CNT_W-1:0]  w_cnt;
   logic [CNT_W-1:0]  w_cnt_inc;
   logic [31:0]       aw_off;
   logic [MEM_AW-1:0] aw_idx;
   logic [1:0]        aw_resp;
   logic              w_beat;
   logic              w_beat_ok;
   logic              w_en;
   logic [1:0]        w_resp_beat;
   logic [1:0]        w_resp_fin;

   // Read engine state
   rd_state_e         r_state;
   logic [MEM_AW-1:0] r_idx;
   logic [MEM_AW-1:0] r_idx_next;
   logic [LEN_W-1:0]  r_len;
   logic [1:0]        r_burst;
   logic [LEN_W-1:0]  r_cnt;
   logic [31:0]       ar_off;
   logic [MEM_AW-1:0] ar_idx;
   logic [1:0]        ar_resp;

   logic unused_inputs;
   assign unused_inputs = ^{AXI_awlock, AXI_awcache, AXI_awprot, AXI_awqos,
                            AXI_arlock, AXI_arcache, AXI_arprot, AXI_arqos, aw_off, ar_off};

   assign aw_off  = AXI_awaddr - BASE_ADDR;
   assign aw_idx  = aw_off[MEM_AW+1:2];
   assign aw_resp = burst_resp(AXI_awaddr, BASE_ADDR, MEM_AW, AXI_awsize, AXI_awburst, AXI_awlen);
   assign ar_off  = AXI_araddr - BASE_ADDR;
   assign ar_idx  = ar_off[MEM_AW+1:2];
   assign ar_resp = burst_resp(AXI_araddr, BASE_ADDR, MEM_AW, AXI_arsize, AXI_arburst, AXI_arlen);

   axi_burst_addr #(.MEM_AW(MEM_AW)) u_wr_addr (
      .idx_i      (w_idx),
      .len_i      (w_len),
      .burst_i    (w_burst),
      .next_idx_o (w_idx_next)
   );

   axi_burst_addr #(.MEM_AW(MEM_AW)) u_rd_addr (
      .idx_i      (r_idx),
      .len_i      (r_len),
      .burst_i    (r_burst),
      .next_idx_o (r_idx_next)
   );

   assign w_beat    = (w_state == WrData) && AXI_wvalid && AXI_wready;
   assign w_beat_ok = (AXI_wid == w_id) && (w_cnt <= {1'b0, w_len});
   assign w_en      = w_beat && w_beat_ok && (w_resp == RESP_OKAY);
   assign w_cnt_inc = (w_cnt == '1) ? w_cnt : w_cnt + CNT_W'(1);

   // A decode error keeps its code; beat-level protocol faults downgrade OKAY to SLVERR.
   always_comb begin
      w_resp_beat = w_resp;
      if (w_resp == RESP_OKAY && !w_beat_ok) w_resp_beat = RESP_SLVERR;
      w_resp_fin = w_resp_beat;
      if (w_resp_beat == RESP_OKAY && w_cnt != {1'b0, w_len}) w_resp_fin = RESP_SLVERR;
   end

   always_ff @(posedge AXI_clk) begin
      if (w_en) begin
         for (int b = 0; b < 4; b++) begin
            if (AXI_wstrb[b]) mem[w_idx][8*b +: 8] <= AXI_wdata[8*b +: 8];
         end
      end
   end

   always_ff @(posedge AXI_clk or posedge rst) begin
      if (rst) begin
         w_state     <= WrIdle;
         AXI_awready <= 1'b0;
         AXI_wready  <= 1'b0;
         AXI_bvalid  <= 1'b0;
         AXI_bid     <= '0;
         AXI_bresp   <= '0;
         w_id        <= '0;
         w_idx       <= '0;
         w_len       <= '0;
         w_burst     <= '0;
         w_resp      <= '0;
         w_cnt       <= '0;
      end else begin
         unique case (w_state)
            WrIdle: begin
               if (AXI_awvalid && AXI_awready) begin
                  w_id        <= AXI_awid;
                  w_idx       <= aw_idx;
                  w_len       <= AXI_awlen;
                  w_burst     <= AXI_awburst;
                  w_resp      <= aw_resp;
                  w_cnt       <= '0;
                  AXI_awready <= 1'b0;
                  AXI_wready  <= 1'b1;
                  w_state     <= WrData;
               end else begin
                  AXI_awready <= 1'b1;
               end
            end
            WrData: begin
               if (w_beat) begin
                  w_idx <= w_idx_next;
                  w_cnt <= w_cnt_inc;
                  if (AXI_wlast) begin
                     AXI_wready <= 1'b0;
                     AXI_bvalid <= 1'b1;
                     AXI_bid    <= w_id;
                     AXI_bresp  <= w_resp_fin;
                     w_state    <= WrResp;
                  end else begin
                     w_resp <= w_resp_beat;
                  end
               end
            end
            WrResp: begin
               if (AXI_bready) begin
                  AXI_bvalid  <= 1'b0;
                  AXI_awready <= 1'b1;
                  w_state     <= WrIdle;
               end
            end
            default: w_state <= WrIdle;
         endcase
      end
   end

   always_ff @(posedge AXI_clk or posedge rst) begin
      if (rst) begin
         r_state     <= RdIdle;
         AXI_arready <= 1'b0;
         AXI_rvalid  <= 1'b0;
         AXI_rdata   <= '0;
         AXI_rid     <= '0;
         AXI_rresp   <= '0;
         AXI_rlast   <= 1'b0;
         r_idx       <= '0;
         r_len       <= '0;
         r_burst     <= '0;
         r_cnt       <= '0;
      end else begin
         unique case (r_state)
            RdIdle: begin
               if (AXI_arvalid && AXI_arready) begin
                  AXI_arready <= 1'b0;
                  AXI_rvalid  <= 1'b1;
                  AXI_rid     <= AXI_arid;
                  AXI_rresp   <= ar_resp;
                  AXI_rdata   <= (ar_resp == RESP_OKAY) ? mem[ar_idx] : '0;
                  AXI_rlast   <= (AXI_arlen == '0);
                  r_idx       <= ar_idx;
                  r_len       <= AXI_arlen;
                  r_burst     <= AXI_arburst;
                  r_cnt       <= '0;
                  r_state     <= RdData;
               end else begin
                  AXI_arready <= 1'b1;
               end
            end
            RdData: begin
               if (AXI_rready) begin
                  if (AXI_rlast) begin
                     AXI_rvalid  <= 1'b0;
                     AXI_rlast   <= 1'b0;
                     AXI_arready <= 1'b1;
                     r_state     <= RdIdle;
                  end else begin
                     r_idx     <= r_idx_next;
                     r_cnt     <= r_cnt + LEN_W'(1);
                     AXI_rdata <= (AXI_rresp == RESP_OKAY) ? mem[r_idx_next] : '0;
                     AXI_rlast <= ((r_cnt + LEN_W'(1)) == r_len);
                  end
               end
            end
            default: r_state <= RdIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_axi_hp_slave_ram.sv
// Directed bench for axi_hp_slave_ram: bursts, strobes, errors, read stalls and mid-burst reset.
module tb_axi_hp_slave_ram;
   import axi3_pkg::*;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        AXI_clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] AXI_awaddr;
   logic [5:0]  AXI_awid;
   logic [3:0]  AXI_awlen;
   logic [2:0]  AXI_awsize;
   logic [1:0]  AXI_awburst;
   logic [1:0]  AXI_awlock;
   logic [3:0]  AXI_awcache;
   logic [2:0]  AXI_awprot;
   logic [3:0]  AXI_awqos;
   logic        AXI_awvalid;
   logic        AXI_awready;
   logic [31:0] AXI_wdata;
   logic [5:0]  AXI_wid;
   logic [3:0]  AXI_wstrb;
   logic        AXI_wlast;
   logic        AXI_wvalid;
   logic        AXI_wready;
   logic [5:0]  AXI_bid;
   logic [1:0]  AXI_bresp;
   logic        AXI_bvalid;
   logic        AXI_bready;
   logic [31:0] AXI_araddr;
   logic [5:0]  AXI_arid;
   logic [3:0]  AXI_arlen;
   logic [2:0]  AXI_arsize;
   logic [1:0]  AXI_arburst;
   logic [1:0]  AXI_arlock;
   logic [3:0]  AXI_arcache;
   logic [2:0]  AXI_arprot;
   logic [3:0]  AXI_arqos;
   logic        AXI_arvalid;
   logic        AXI_arready;
   logic [31:0] AXI_rdata;
   logic [5:0]  AXI_rid;
   logic [1:0]  AXI_rresp;
   logic        AXI_rlast;
   logic        AXI_rvalid;
   logic        AXI_rready;

   always #5 AXI_clk = ~AXI_clk;

   axi_hp_slave_ram dut (
      .AXI_clk(AXI_clk), .rst(rst),
      .AXI_awaddr(AXI_awaddr), .AXI_awid(AXI_awid), .AXI_awlen(AXI_awlen),
      .AXI_awsize(AXI_awsize), .AXI_awburst(AXI_awburst), .AXI_awlock(AXI_awlock),
      .AXI_awcache(AXI_awcache), .AXI_awprot(AXI_awprot), .AXI_awqos(AXI_awqos),
      .AXI_awvalid(AXI_awvalid), .AXI_awready(AXI_awready),
      .AXI_wdata(AXI_wdata), .AXI_wid(AXI_wid), .AXI_wstrb(AXI_wstrb), .AXI_wlast(AXI_wlast),
      .AXI_wvalid(AXI_wvalid), .AXI_wready(AXI_wready),
      .AXI_bid(AXI_bid), .AXI_bresp(AXI_bresp), .AXI_bvalid(AXI_bvalid), .AXI_bready(AXI_bready),
      .AXI_araddr(AXI_araddr), .AXI_arid(AXI_arid), .AXI_arlen(AXI_arlen),
      .AXI_arsize(AXI_arsize), .AXI_arburst(AXI_arburst), .AXI_arlock(AXI_arlock),
      .AXI_arcache(AXI_arcache), .AXI_arprot(AXI_arprot), .AXI_arqos(AXI_arqos),
      .AXI_arvalid(AXI_arvalid), .AXI_arready(AXI_arready),
      .AXI_rdata(AXI_rdata), .AXI_rid(AXI_rid), .AXI_rresp(AXI_rresp), .AXI_rlast(AXI_rlast),
      .AXI_rvalid(AXI_rvalid), .AXI_rready(AXI_rready)
   );

   int n_cmp = 0;
   int n_bad = 0;

   logic [31:0] wbuf [16];
   logic [3:0]  wstrb_v;
   logic [1:0]  wr_resp;
   logic [5:0]  wr_id;
   logic [31:0] rd_data [16];
   logic        rd_last [16];
   logic [1:0]  rd_resp;
   logic [5:0]  rd_id;
   int          rd_n;
   int          rd_wait;
   logic [31:0] obs_data [32];
   logic        obs_last [32];
   time         aw_t;
   time         ar_t;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h", tag, got, exp);
      end
   endtask

   task automatic axi_write(input logic [31:0] addr, input logic [5:0] id, input logic [3:0] len,
                            input logic [1:0] burst, input logic [2:0] size);
      int n;
      @(negedge AXI_clk);
      AXI_awaddr = addr; AXI_awid = id; AXI_awlen = len; AXI_awburst = burst;
      AXI_awsize = size; AXI_awvalid = 1'b1;
      n = 0;
      while (!AXI_awready && n < 20) begin @(negedge AXI_clk); n++; end
      if (n >= 20) check("aw_timeout", 32'd0, 32'd1);
      @(posedge AXI_clk); aw_t = $time; #1 AXI_awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         @(negedge AXI_clk);
         AXI_wdata = wbuf[i]; AXI_wid = id; AXI_wstrb = wstrb_v;
         AXI_wlast = (i == int'(len)); AXI_wvalid = 1'b1;
         n = 0;
         while (!AXI_wready && n < 20) begin @(negedge AXI_clk); n++; end
         if (n >= 20) check("w_timeout", 32'd0, 32'd1);
         @(posedge AXI_clk); #1 AXI_wvalid = 1'b0; AXI_wlast = 1'b0;
      end
      @(negedge AXI_clk);
      AXI_bready = 1'b1;
      n = 0;
      while (!AXI_bvalid && n < 20) begin @(negedge AXI_clk); n++; end
      if (n >= 20) check("b_timeout", 32'd0, 32'd1);
      wr_resp = AXI_bresp; wr_id = AXI_bid;
      @(posedge AXI_clk); #1 AXI_bready = 1'b0;
   endtask

   // stall bit k drops rready on the k-th cycle that rvalid is seen
   task automatic axi_read(input logic [31:0] addr, input logic [5:0] id, input logic [3:0] len,
                           input logic [1:0] burst, input logic [15:0] stall);
      int n;
      int cyc;
      bit done;
      @(negedge AXI_clk);
      AXI_araddr = addr; AXI_arid = id; AXI_arlen = len; AXI_arburst = burst;
      AXI_arsize = SIZE_4B; AXI_arvalid = 1'b1;
      n = 0;
      while (!AXI_arready && n < 20) begin @(negedge AXI_clk); n++; end
      if (n >= 20) check("ar_timeout", 32'd0, 32'd1);
      @(posedge AXI_clk); ar_t = $time; #1 AXI_arvalid = 1'b0;
      rd_n = 0; rd_wait = 0; cyc = 0; done = 1'b0;
      while (!done && (rd_wait + cyc) < 60) begin
         @(negedge AXI_clk);
         if (!AXI_rvalid) begin
            AXI_rready = 1'b0;
            rd_wait++;
         end else begin
            AXI_rready = (cyc < 16) ? !stall[cyc] : 1'b1;
            if (cyc < 32) begin
               obs_data[cyc] = AXI_rdata;
               obs_last[cyc] = AXI_rlast;
            end
            if (AXI_rready && rd_n < 16) begin
               rd_data[rd_n] = AXI_rdata; rd_last[rd_n] = AXI_rlast;
               rd_resp = AXI_rresp; rd_id = AXI_rid;
               rd_n++;
               done = AXI_rlast;
            end
            cyc++;
         end
      end
      if (!done) check("r_timeout", 32'd0, 32'd1);
      @(posedge AXI_clk); #1 AXI_rready = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      AXI_awaddr = '0; AXI_awid = '0; AXI_awlen = '0; AXI_awsize = SIZE_4B; AXI_awburst = BURST_INCR;
      AXI_awlock = '0; AXI_awcache = '0; AXI_awprot = '0; AXI_awqos = '0; AXI_awvalid = 1'b0;
      AXI_wdata = '0; AXI_wid = '0; AXI_wstrb = '0; AXI_wlast = 1'b0; AXI_wvalid = 1'b0;
      AXI_bready = 1'b0;
      AXI_araddr = '0; AXI_arid = '0; AXI_arlen = '0; AXI_arsize = SIZE_4B; AXI_arburst = BURST_INCR;
      AXI_arlock = '0; AXI_arcache = '0; AXI_arprot = '0; AXI_arqos = '0; AXI_arvalid = 1'b0;
      AXI_rready = 1'b0;
      wstrb_v = 4'hF;
      for (int i = 0; i < 16; i++) wbuf[i] = '0;

      // reset state, then readies one edge after release
      repeat (3) @(posedge AXI_clk);
      @(negedge AXI_clk);
      check("rst_awready", 32'(AXI_awready), 32'd0);
      check("rst_arready", 32'(AXI_arready), 32'd0);
      check("rst_valids", 32'({AXI_wready, AXI_bvalid, AXI_rvalid}), 32'd0);
      rst = 1'b0;
      @(negedge AXI_clk);
      check("post_rst_awready", 32'(AXI_awready), 32'd1);
      check("post_rst_arready", 32'(AXI_arready), 32'd1);

      // INCR write and readback
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hA0 + 32'(i);
      axi_write(BASE + 32'h10, 6'd5, 4'd3, BURST_INCR, SIZE_4B);
      check("incr_bresp", 32'(wr_resp), 32'(RESP_OKAY));
      check("incr_bid", 32'(wr_id), 32'd5);
      axi_read(BASE + 32'h10, 6'd9, 4'd3, BURST_INCR, 16'h0);
      check("incr_rlat", 32'(rd_wait), 32'd0);
      check("incr_nbeats", 32'(rd_n), 32'd4);
      for (int i = 0; i < 4; i++) begin
         check($sformatf("incr_rdata%0d", i), rd_data[i], 32'hA0 + 32'(i));
         check($sformatf("incr_rlast%0d", i), 32'(rd_last[i]), 32'(i == 3));
      end
      check("incr_rid", 32'(rd_id), 32'd9);
      check("incr_rresp", 32'(rd_resp), 32'(RESP_OKAY));

      // byte strobes
      wbuf[0] = 32'h1234_5678;
      axi_write(BASE + 32'h20, 6'd1, 4'd0, BURST_INCR, SIZE_4B);
      wbuf[0] = 32'hFFFF_FFFF; wstrb_v = 4'b0101;
      axi_write(BASE + 32'h20, 6'd1, 4'd0, BURST_INCR, SIZE_4B);
      wstrb_v = 4'hF;
      axi_read(BASE + 32'h20, 6'd2, 4'd0, BURST_INCR, 16'h0);
      check("strb_rdata", rd_data[0], 32'h12FF_56FF);

      // unsupported size: SLVERR and no write
      wbuf[0] = 32'h0BAD_0BAD;
      axi_write(BASE + 32'h20, 6'd3, 4'd0, BURST_INCR, 3'b001);
      check("size_bresp", 32'(wr_resp), 32'(RESP_SLVERR));
      axi_read(BASE + 32'h20, 6'd2, 4'd0, BURST_INCR, 16'h0);
      check("size_nowrite", rd_data[0], 32'h12FF_56FF);

      // FIXED bursts
      wbuf[0] = 32'd1; wbuf[1] = 32'd2; wbuf[2] = 32'd3;
      axi_write(BASE + 32'h40, 6'd4, 4'd2, BURST_FIXED, SIZE_4B);
      check("fixed_bresp", 32'(wr_resp), 32'(RESP_OKAY));
      axi_read(BASE + 32'h40, 6'd4, 4'd2, BURST_FIXED, 16'h0);
      for (int i = 0; i < 3; i++) check($sformatf("fixed_rdata%0d", i), rd_data[i], 32'd3);

      // WRAP: start at word 22 of window 20..23
      for (int i = 0; i < 4; i++) wbuf[i] = 32'hB0 + 32'(i);
      axi_write(BASE + 32'h58, 6'd7, 4'd3, BURST_WRAP, SIZE_4B);
      check("wrap_bresp", 32'(wr_resp), 32'(RESP_OKAY));
      axi_read(BASE + 32'h50, 6'd7, 4'd3, BURST_INCR, 16'h0);
      check("wrap_rdata0", rd_data[0], 32'hB2);
      check("wrap_rdata1", rd_data[1], 32'hB3);
      check("wrap_rdata2", rd_data[2], 32'hB0);
      check("wrap_rdata3", rd_data[3], 32'hB1);

      // out-of-range addresses
      wbuf[0] = 32'h55AA_55AA;
      axi_write(BASE, 6'd1, 4'd0, BURST_INCR, SIZE_4B);
      wbuf[0] = 32'hDEAD_BEEF;
      axi_write(BASE + 32'h1000, 6'd1, 4'd0, BURST_INCR, SIZE_4B);
      check("oor_bresp", 32'(wr_resp), 32'(RESP_DECERR));
      axi_read(BASE, 6'd1, 4'd0, BURST_INCR, 16'h0);
      check("oor_nowrite", rd_data[0], 32'h55AA_55AA);
      axi_read(BASE - 32'd4, 6'd8, 4'd0, BURST_INCR, 16'h0);
      check("oor_rresp", 32'(rd_resp), 32'(RESP_DECERR));
      check("oor_rdata", rd_data[0], 32'd0);
      check("oor_rlast", 32'(rd_last[0]), 32'd1);

      // rready 1-0-0-1 stall: beat 1 held for three cycles
      axi_read(BASE + 32'h10, 6'd3, 4'd3, BURST_INCR, 16'b0110);
      check("stall_nbeats", 32'(rd_n), 32'd4);
      check("stall_c0", obs_data[0], 32'hA0);
      check("stall_c1", obs_data[1], 32'hA1);
      check("stall_c2", obs_data[2], 32'hA1);
      check("stall_c3", obs_data[3], 32'hA1);
      check("stall_c4", obs_data[4], 32'hA2);
      check("stall_c5", obs_data[5], 32'hA3);
      check("stall_last_c2", 32'(obs_last[2]), 32'd0);
      check("stall_last_c5", 32'(obs_last[5]), 32'd1);

      // concurrent AW and AR
      wbuf[0] = 32'h77;
      fork
         axi_write(BASE + 32'h100, 6'd11, 4'd0, BURST_INCR, SIZE_4B);
         axi_read(BASE + 32'h10, 6'd12, 4'd0, BURST_INCR, 16'h0);
      join
      check("conc_same_cycle", 32'(aw_t - ar_t), 32'd0);
      check("conc_bresp", 32'(wr_resp), 32'(RESP_OKAY));
      check("conc_rdata", rd_data[0], 32'hA0);
      check("conc_rid", 32'(rd_id), 32'd12);

      // reset during beat 2 of an 8-beat write
      for (int i = 0; i < 8; i++) wbuf[i] = 32'h0;
      axi_write(BASE + 32'h80, 6'd4, 4'd7, BURST_INCR, SIZE_4B);
      @(negedge AXI_clk);
      AXI_awaddr = BASE + 32'h80; AXI_awid = 6'd4; AXI_awlen = 4'd7; AXI_awburst = BURST_INCR;
      AXI_awsize = SIZE_4B; AXI_awvalid = 1'b1;
      for (int n = 0; n < 20 && !AXI_awready; n++) @(negedge AXI_clk);
      @(posedge AXI_clk); #1 AXI_awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         @(negedge AXI_clk);
         AXI_wdata = 32'hC0 + 32'(i); AXI_wid = 6'd4; AXI_wstrb = 4'hF; AXI_wvalid = 1'b1;
         for (int n = 0; n < 20 && !AXI_wready; n++) @(negedge AXI_clk);
         @(posedge AXI_clk); #1 AXI_wvalid = 1'b0;
      end
      @(negedge AXI_clk);
      AXI_wdata = 32'hC2; AXI_wvalid = 1'b1;
      #1 rst = 1'b1;
      #1;
      check("midrst_readies", 32'({AXI_awready, AXI_wready, AXI_arready}), 32'd0);
      check("midrst_valids", 32'({AXI_bvalid, AXI_rvalid}), 32'd0);
      @(negedge AXI_clk);
      AXI_wvalid = 1'b0;
      rst = 1'b0;
      wbuf[0] = 32'h11;
      axi_write(BASE + 32'h200, 6'd6, 4'd0, BURST_INCR, SIZE_4B);
      check("postrst_bresp", 32'(wr_resp), 32'(RESP_OKAY));
      check("postrst_bid", 32'(wr_id), 32'd6);
      axi_read(BASE + 32'h80, 6'd5, 4'd2, BURST_INCR, 16'h0);
      check("postrst_beat0", rd_data[0], 32'hC0);
      check("postrst_beat1", rd_data[1], 32'hC1);
      check("postrst_beat2", rd_data[2], 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/axi_hp_slave_ram.md
Name: axi_hp_slave_ram

Overview:
- AXI3 slave (responder) backed by a local word array; the target end of the HP0 burst protocol that AXI2S drives as initiator.
- Lets the stream-to-AXI path run in simulation and on-fabric loopback without the PS/DDR.
- Independent read and write engines:
  - one outstanding transaction per direction;
  - 32-bit data, 6-bit IDs, 4-bit burst length (AXI3).

Parameters:
BASE_ADDR, 32'h1000_0000, byte address mapped to word 0
MEM_AW, 10, word-address width (depth 2^MEM_AW words, default 4 KB)

Ports:
AXI_clk  in  1  single clock
rst  in  1  asynchronous, active-high reset
AXI_awaddr/awid/awlen/awsize/awburst  in  32/6/4/3/2  write address channel
AXI_awlock/awcache/awprot/awqos  in  2/4/3/4  accepted, ignored
AXI_awvalid in 1; AXI_awready out 1  AW handshake
AXI_wdata/wid/wstrb/wlast/wvalid  in  32/6/4/1/1  write data channel
AXI_wready  out  1  W handshake
AXI_bid/bresp/bvalid  out  6/2/1  write response; AXI_bready in 1
AXI_araddr/arid/arlen/arsize/arburst  in  32/6/4/3/2  read address channel
AXI_arlock/arcache/arprot/arqos  in  2/4/3/4  accepted, ignored
AXI_arvalid in 1; AXI_arready out 1  AR handshake
AXI_rdata/rid/rresp/rlast/rvalid  out  32/6/2/1/1  read data; AXI_rready in 1

Behaviour:
- Reset state: all outputs 0, both FSMs in IDLE. awready/arready rise on the first clock edge after rst falls. Memory array is not reset.
- rst asserted mid-burst: immediately abandons the transaction and drops all valids/readies. Words already written stay written.
- Address decode:
  - word index = (addr - BASE_ADDR) >> 2;
  - out of range (addr < BASE_ADDR, or index >= 2^MEM_AW) -> DECERR (2'b11);
  - awsize/arsize != 3'b010 or burst == 2'b11 -> SLVERR (2'b10);
  - otherwise OKAY (2'b00); exclusive lock still returns OKAY;
  - error is latched per burst at address accept. Any error suppresses all array writes for that burst and forces rdata=0.
- Burst addressing:
  - INCR: index +1 per beat, wrapping modulo 2^MEM_AW;
  - FIXED: index constant;
  - WRAP (2'b10): wraps on the (len+1)*4-byte aligned boundary. len must be 1/3/7/15, else SLVERR.
- Write FSM:
  - W_IDLE (awready=1): on awvalid&awready, capture id/index/len/burst/err -> W_DATA.
  - W_DATA (wready=1): per beat, bytes with wstrb[i]=1 are written unless err. Beat counter increments.
    - wid != captured awid -> sticky SLVERR.
    - Beats beyond len are consumed but not written, and set SLVERR.
    - On the wlast beat -> W_RESP. If the counter != len at wlast -> SLVERR.
  - W_RESP: bvalid=1 the cycle after the wlast handshake, bid=awid; held until bready -> W_IDLE. awready returns the following cycle.
- Read FSM:
  - R_IDLE (arready=1): on AR handshake -> R_DATA. rvalid=1 with beat 0 on the next cycle (latency 1).
  - R_DATA: rdata/rid/rresp/rlast are registered and held stable while rvalid & ~rready.
    - Each handshake loads the next beat. Back-to-back beats flow at 1/cycle when rready stays high.
    - rlast=1 on beat len. Handshake of the last beat -> R_IDLE, rvalid=0 the next cycle.
- Array is asynchronous-read, synchronous byte-enable write.
  - Same-edge read-load and write to the same word: rdata gets the pre-write (old) value.
  - A write completed on an earlier edge is always visible.
- Read and write engines run fully concurrently; no arbitration.

Decomposition:
- Shared package axi3_pkg holds:
  - BURST_FIXED/INCR/WRAP;
  - RESP_OKAY/EXOKAY/SLVERR/DECERR;
  - SIZE_4B = 3'b010;
  - ID width 6, LEN width 4.
- One sub-module axi_burst_addr, instantiated twice (read and write): combinational next-index calculation from (index, len, burst) including WRAP boundary masking.

Test Plan:
- INCR write awaddr=BASE+0x10, awlen=3, data 0xA0..0xA3, wstrb=4'hF, then INCR read same -> bresp=0, rdata A0,A1,A2,A3, rlast on 4th, rid=arid.
- wstrb=4'b0101 writing 0xFFFFFFFF over 0x12345678 -> readback 0x12FF56FF.
- FIXED write len=2 of 1,2,3 to BASE+0x40 -> word holds 3; FIXED read len=2 returns 3,3,3.
- awaddr=BASE+0x1000 (out of range) len=0 -> bresp=2'b11; memory unchanged. araddr=BASE-4 -> rresp=2'b11, rdata=0.
- rready toggled 1-0-0-1 during a len=3 read -> rdata/rlast stable while stalled, no beat lost. Simultaneous AW and AR both accepted same cycle.
- rst pulsed during W_DATA beat 2 of len=7 -> all valids 0 at once; post-reset new burst completes OKAY; beats 0-1 persisted.
